// File: rtl/rida_pkg.sv
// rida_pkg: shared sequencer state encoding and instruction field constants for the RIDA core
package rida_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    ERROR  = 3'd6
  } seq_state_t;
  localparam logic [1:0] TIPO_REG  = 2'b00;
  localparam logic [1:0] TIPO_IMM  = 2'b01;
  localparam logic [1:0] TIPO_MEM  = 2'b10;
  localparam logic [1:0] TIPO_CTRL = 2'b11;
  localparam logic [1:0] COND_AL = 2'b00;
  localparam logic [1:0] COND_EQ = 2'b01;
  localparam logic [1:0] COND_NE = 2'b10;
  localparam logic [1:0] COND_LT = 2'b11;
  localparam logic [2:0] OP_HALT = 3'b111;
endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: control-unit, memory-handshake and enable signals between sequencer and datapath
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       cond;
  logic [1:0]       tipo;
  logic [2:0]       opcode;
  logic             reg_write_d;
  logic             mem_write_d;
  logic             branch_d;
  logic [3:0]       flags;
  logic             imem_ready;
  logic             dmem_ready;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             imem_req;
  logic             dmem_req;
  logic             mem_write;
  logic             reg_write;
  logic             flag_write;
  logic [2:0]       state;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] instr_count;
  modport master (
    input  cond, tipo, opcode, reg_write_d, mem_write_d, branch_d, flags, imem_ready, dmem_ready,
    output ir_write, pc_write, pc_src, imem_req, dmem_req, mem_write, reg_write, flag_write,
           state, halted, error, instr_count
  );
  modport slave (
    output cond, tipo, opcode, reg_write_d, mem_write_d, branch_d, flags, imem_ready, dmem_ready,
    input  ir_write, pc_write, pc_src, imem_req, dmem_req, mem_write, reg_write, flag_write,
           state, halted, error, instr_count
  );
endinterface

// File: rtl/multicycle_sequencer_cond_check.sv
// cond_check: evaluates the 2-bit condition field against the {N,Z,C,V} flags
module cond_check
  import rida_pkg::*;
(
  input  logic [1:0] cond,
  input  logic [3:0] flags,
  output logic       cpass
);
  logic unused_carry;
  assign unused_carry = flags[1];
  assign cpass = cond == COND_AL ? 1'b1 :
                 cond == COND_EQ ? flags[2] :
                 cond == COND_NE ? !flags[2] :
                 flags[3] ^ flags[0];
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FSM stepping the RIDA datapath through fetch/decode/exec/mem/wb with memory watchdogs
module multicycle_sequencer
  import rida_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_sequencer_if.master bus
);
  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WT_W-1:0] WT_MAX = WT_W'(MEM_TIMEOUT - 1);
  seq_state_t       state_q;
  logic [WT_W-1:0]  wait_q;
  logic [CNT_W-1:0] count_q;
  logic             flag_write_q, reg_write_q, dmem_req_q, mem_write_q, pc_br_q;
  logic             cpass, is_halt, imem_hit, is_alu;
  cond_check u_cond (.cond(bus.cond), .flags(bus.flags), .cpass(cpass));
  assign is_halt  = bus.tipo == TIPO_CTRL && bus.opcode == OP_HALT;
  assign is_alu   = bus.tipo == TIPO_REG || bus.tipo == TIPO_IMM;
  assign imem_hit = state_q == FETCH && bus.imem_ready && !rst;
  // Enables for the upcoming state are registered on the way in; wait_q clears unless the state holds.
  always_ff @(posedge clk) begin
    flag_write_q <= 1'b0;
    reg_write_q  <= 1'b0;
    dmem_req_q   <= 1'b0;
    mem_write_q  <= 1'b0;
    pc_br_q      <= 1'b0;
    wait_q       <= '0;
    if (rst) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.imem_ready) state_q <= DECODE;
          else if (wait_q == WT_MAX) state_q <= ERROR;
          else wait_q <= wait_q + 1'b1;
        end
        DECODE: begin
          state_q      <= EXEC;
          flag_write_q <= !is_halt && cpass && is_alu;
          pc_br_q      <= !is_halt && cpass && bus.tipo == TIPO_CTRL && bus.branch_d;
        end
        EXEC: begin
          if (is_halt) begin
            state_q <= HALT;
            count_q <= count_q + 1'b1;
          end else if (!cpass || bus.tipo == TIPO_CTRL) begin
            state_q <= FETCH;
            count_q <= count_q + 1'b1;
          end else if (bus.tipo == TIPO_MEM) begin
            state_q     <= MEM;
            dmem_req_q  <= 1'b1;
            mem_write_q <= bus.mem_write_d;
          end else begin
            state_q     <= WB;
            reg_write_q <= bus.reg_write_d;
          end
        end
        MEM: begin
          if (bus.dmem_ready && bus.mem_write_d) begin
            state_q <= FETCH;
            count_q <= count_q + 1'b1;
          end else if (bus.dmem_ready) begin
            state_q     <= WB;
            reg_write_q <= bus.reg_write_d;
          end else if (wait_q == WT_MAX) begin
            state_q <= ERROR;
          end else begin
            wait_q      <= wait_q + 1'b1;
            dmem_req_q  <= 1'b1;
            mem_write_q <= bus.mem_write_d;
          end
        end
        WB: begin
          state_q <= FETCH;
          count_q <= count_q + 1'b1;
        end
        default: state_q <= state_q;
      endcase
    end
  end
  // Reset masks every request/enable in its own cycle so an in-flight access is abandoned.
  assign bus.imem_req    = state_q == FETCH && !rst;
  assign bus.ir_write    = imem_hit;
  assign bus.pc_write    = imem_hit || (pc_br_q && !rst);
  assign bus.pc_src      = pc_br_q && !rst;
  assign bus.dmem_req    = dmem_req_q && !rst;
  assign bus.mem_write   = mem_write_q && !rst;
  assign bus.reg_write   = reg_write_q && !rst;
  assign bus.flag_write  = flag_write_q && !rst;
  assign bus.state       = state_q;
  assign bus.halted      = state_q == HALT;
  assign bus.error       = state_q == ERROR;
  assign bus.instr_count = count_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: per-instruction timeline model checked every cycle, plus directed literal checks
module tb_multicycle_sequencer;
  import rida_pkg::*;
  localparam int T = 16;
  typedef struct packed {
    logic        imem_req, ir_write, pc_write, pc_src, dmem_req, mem_write, reg_write, flag_write, halted, error;
    logic [2:0]  state;
    logic [31:0] cnt;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  multicycle_sequencer_if #(.CNT_W(32)) bus ();
  multicycle_sequencer #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  obs_t        exp_q[$];
  obs_t        act_o, exp_o;
  int          n_cmp = 0, n_bad = 0, n_cyc = 0;
  int          n_rw = 0, n_fw = 0, n_mw = 0, n_dreq = 0, n_ireq = 0, n_pcw = 0, n_pcsrc = 0;
  logic [31:0] cnt = '0;
  seq_state_t  mstate = FETCH;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_o = exp_q.pop_front();
      act_o = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.dmem_req, bus.mem_write,
               bus.reg_write, bus.flag_write, bus.halted, bus.error, bus.state, bus.instr_count};
      n_cmp++;
      if (act_o !== exp_o) begin
        n_bad++;
        $display("FAIL seq_outputs t=%0t got %h want %h (state %0d/%0d cnt %0d/%0d)", $time,
                 act_o, exp_o, act_o.state, exp_o.state, act_o.cnt, exp_o.cnt);
      end
      n_cyc++;
      n_rw    += int'(act_o.reg_write);
      n_fw    += int'(act_o.flag_write);
      n_mw    += int'(act_o.mem_write);
      n_dreq  += int'(act_o.dmem_req);
      n_ireq  += int'(act_o.imem_req);
      n_pcw   += int'(act_o.pc_write);
      n_pcsrc += int'(act_o.pc_src);
    end
  end
  task automatic lit(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask
  task automatic clr();
    n_cyc = 0; n_rw = 0; n_fw = 0; n_mw = 0; n_dreq = 0; n_ireq = 0; n_pcw = 0; n_pcsrc = 0;
  endtask
  function automatic obs_t mk(input seq_state_t s);
    obs_t e;
    e = '0;
    e.state    = s;
    e.imem_req = s == FETCH;
    e.halted   = s == HALT;
    e.error    = s == ERROR;
    e.cnt      = cnt;
    return e;
  endfunction
  task automatic cyc(input logic ir, input logic dr, input logic r, input obs_t e);
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    rst = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input seq_state_t s);
    obs_t e;
    e = mk(s);
    e.imem_req = 1'b0;
    cyc(1'($urandom), 1'($urandom), 1'b1, e);
    cnt = '0;
    mstate = FETCH;
  endtask
  task automatic idle_terminal(input int n);
    for (int k = 0; k < n; k++) cyc(1'($urandom), 1'($urandom), 1'b0, mk(mstate));
    do_reset(mstate);
  endtask
  // One instruction as a cycle-by-cycle timeline: fetch latency fl, memory latency ml, optional reset at MEM cycle rm.
  task automatic do_instr(input logic [1:0] c, input logic [1:0] t, input logic [2:0] op, input logic rw,
                          input logic mw, input logic br, input logic [3:0] f, input int fl, input int ml,
                          input int rm);
    obs_t e;
    logic cp, hlt;
    bus.cond = c; bus.tipo = t; bus.opcode = op; bus.reg_write_d = rw; bus.mem_write_d = mw;
    bus.branch_d = br; bus.flags = f;
    for (int i = 0; i < T; i++) begin
      e = mk(FETCH);
      e.ir_write = i == fl;
      e.pc_write = i == fl;
      cyc(i == fl, 1'($urandom), 1'b0, e);
      if (i == fl) break;
    end
    if (fl >= T) begin
      mstate = ERROR;
      return;
    end
    cyc(1'($urandom), 1'($urandom), 1'b0, mk(DECODE));
    case (c)
      2'd0:    cp = 1'b1;
      2'd1:    cp = f[2];
      2'd2:    cp = !f[2];
      default: cp = f[3] != f[0];
    endcase
    hlt = t == 2'd3 && op == 3'd7;
    e = mk(EXEC);
    e.flag_write = !hlt && cp && t < 2'd2;
    e.pc_write   = !hlt && cp && t == 2'd3 && br;
    e.pc_src     = e.pc_write;
    cyc(1'($urandom), 1'($urandom), 1'b0, e);
    if (hlt) begin
      cnt++;
      mstate = HALT;
      return;
    end
    if (!cp || t == 2'd3) begin
      cnt++;
      return;
    end
    if (t == 2'd2) begin
      for (int j = 0; j < T; j++) begin
        if (j == rm) begin
          do_reset(MEM);
          return;
        end
        e = mk(MEM);
        e.dmem_req  = 1'b1;
        e.mem_write = mw;
        cyc(1'($urandom), j == ml, 1'b0, e);
        if (j == ml) break;
      end
      if (ml >= T) begin
        mstate = ERROR;
        return;
      end
      if (mw) begin
        cnt++;
        return;
      end
    end
    e = mk(WB);
    e.reg_write = rw;
    cyc(1'($urandom), 1'($urandom), 1'b0, e);
    cnt++;
  endtask
  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 99);
    return r < 3 ? 16 + $urandom_range(0, 2) : r < 8 ? 15 : $urandom_range(0, 3);
  endfunction
  initial begin
    int fl, ml, rm;
    bus.cond = '0; bus.tipo = '0; bus.opcode = '0; bus.reg_write_d = 1'b0; bus.mem_write_d = 1'b0;
    bus.branch_d = 1'b0; bus.flags = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset_state", int'(bus.state), 0);
    lit("reset_count", int'(bus.instr_count), 0);
    clr(); do_instr(COND_AL, TIPO_REG, 3'd0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0, -1);
    lit("reg_add_cycles", n_cyc, 4);
    lit("reg_add_count", int'(bus.instr_count), 1);
    lit("reg_add_flag_write", n_fw, 1);
    lit("reg_add_reg_write", n_rw, 1);
    clr(); do_instr(COND_AL, TIPO_MEM, 3'd0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 3, -1);
    lit("load_dmem_req_cycles", n_dreq, 4);
    lit("load_reg_write", n_rw, 1);
    lit("load_mem_write", n_mw, 0);
    clr(); do_instr(COND_AL, TIPO_MEM, 3'd0, 1'b0, 1'b1, 1'b0, 4'h0, 0, 3, -1);
    lit("store_mem_write_cycles", n_mw, 4);
    lit("store_reg_write", n_rw, 0);
    clr(); do_instr(COND_EQ, TIPO_CTRL, 3'd0, 1'b0, 1'b0, 1'b1, 4'b0100, 0, 0, -1);
    lit("beq_taken_pc_src", n_pcsrc, 1);
    lit("beq_taken_pc_write", n_pcw, 2);
    clr(); do_instr(COND_EQ, TIPO_CTRL, 3'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 0, 0, -1);
    lit("beq_not_taken_pc_src", n_pcsrc, 0);
    lit("beq_not_taken_pc_write", n_pcw, 1);
    lit("beq_not_taken_count", int'(bus.instr_count), 5);
    clr(); do_instr(COND_AL, TIPO_REG, 3'd0, 1'b1, 1'b0, 1'b0, 4'h0, 16, 0, -1);
    lit("timeout_fetch_cycles", n_cyc, 16);
    lit("timeout_error", int'(bus.error), 1);
    idle_terminal(4);
    lit("error_reset_count", int'(bus.instr_count), 0);
    do_instr(COND_AL, TIPO_CTRL, OP_HALT, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, -1);
    lit("halt_halted", int'(bus.halted), 1);
    lit("halt_count", int'(bus.instr_count), 1);
    clr(); idle_terminal(4);
    lit("halt_no_imem_req", n_ireq, 0);
    lit("halt_reset_count", int'(bus.instr_count), 0);
    clr(); do_instr(COND_AL, TIPO_MEM, 3'd0, 1'b0, 1'b1, 1'b0, 4'h0, 0, 6, 2);
    lit("mem_reset_state", int'(bus.state), 0);
    lit("mem_reset_mem_write", n_mw, 2);
    clr(); do_instr(COND_AL, TIPO_REG, 3'd0, 1'b1, 1'b0, 1'b0, 4'h0, 15, 0, -1);
    lit("ready_at_threshold_cycles", n_cyc, 19);
    lit("ready_at_threshold_error", int'(bus.error), 0);
    for (int n = 0; n < 400; n++) begin
      fl = pick_lat();
      ml = pick_lat();
      rm = $urandom_range(0, 19) == 0 ? int'($urandom_range(0, ml < 15 ? ml : 15)) : -1;
      do_instr(2'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               4'($urandom), fl, ml, rm);
      if (mstate == HALT || mstate == ERROR) idle_terminal(int'($urandom_range(2, 5)));
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle state machine that sequences the RIDA datapath: instruction fetch, decode, execute, memory, writeback.
- Gates the per-instruction strobes from the combinational control unit (RegWrite, MemWrite, Branch) into single-cycle enables at the correct state.
- Evaluates the 2-bit condition field against the NZCV flags.
- Handles ready handshakes for instruction memory and data memory, with a watchdog on each.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles to wait for imem_ready or dmem_ready before entering ERROR.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cond  input  2  instruction condition field
- tipo  input  2  instruction type: 00 REG, 01 IMM, 10 MEM, 11 CTRL
- opcode  input  3  instruction opcode
- reg_write_d  input  1  RegWrite from the control unit
- mem_write_d  input  1  MemWrite from the control unit
- branch_d  input  1  Branch from the control unit
- flags  input  4  NZCV from the flag register, {N,Z,C,V}
- imem_ready  input  1  instruction-memory read complete
- dmem_ready  input  1  data-memory access complete
- ir_write  output  1  latch instruction register
- pc_write  output  1  update PC
- pc_src  output  1  0 = PC+1, 1 = branch target
- imem_req  output  1  instruction fetch request
- dmem_req  output  1  data-memory request
- mem_write  output  1  data-memory write enable
- reg_write  output  1  register-file write enable
- flag_write  output  1  flag-register update enable
- state  output  3  current state, for debug
- halted  output  1  sequencer in HALT
- error  output  1  sequencer in ERROR
- instr_count  output  CNT_W  number of retired instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
- Reset, synchronous and overriding all else: state=FETCH, all enables 0, instr_count=0, wait counter=0.
- Reset mid-access aborts the access; no enables are asserted on the reset cycle.
- Condition pass (cpass): 00 always; 01 Z; 10 !Z; 11 N^V.

FETCH:
- imem_req=1.
- On imem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- Otherwise the wait counter increments.
- When the counter reaches MEM_TIMEOUT-1 without ready: go to ERROR.

DECODE:
- One cycle, no enables; go to EXEC.
- cond, tipo, opcode and the *_d inputs are sampled in DECODE/EXEC and must be stable while the IR holds.

EXEC, with tipo and cond decoding:
- tipo=CTRL and opcode=111: go to HALT. This is treated as retired.
- cpass=0: the instruction is a NOP; retire and go to FETCH.
- tipo=CTRL and branch_d: pc_write=1, pc_src=1; retire and go to FETCH.
- tipo=CTRL without branch_d: retire and go to FETCH.
- tipo=REG or IMM: flag_write=1; go to WB.
- tipo=MEM: go to MEM.

MEM:
- dmem_req=1 held until dmem_ready; mem_write=mem_write_d held for the same duration.
- On ready, store (mem_write_d=1): retire and go to FETCH.
- On ready, load: go to WB.
- Same timeout rule as FETCH, leading to ERROR.

WB:
- reg_write=reg_write_d for exactly one cycle; retire and go to FETCH.

Counters and terminal states:
- Retire means instr_count increments by 1 on the transition out of the state.
- instr_count wraps modulo 2^CNT_W.
- The wait counter clears on every state change.
- HALT and ERROR are sticky until rst; all enables stay 0 there.
- halted=(state==HALT); error=(state==ERROR).

Output timing:
- All outputs are registered-state decodes (Moore), except the ready-qualified ir_write/pc_write in FETCH, which are Mealy on imem_ready.
- No write enable is ever asserted for more than one cycle, except mem_write, which is held with dmem_req.
- A ready arriving on the same cycle as the timeout threshold counts as success.

Decomposition:
- Shared package rida_pkg holds:
  - the state enum seq_state_t;
  - tipo constants TIPO_REG/IMM/MEM/CTRL;
  - cond constants COND_AL/EQ/NE/LT;
  - OP_HALT=3'b111.
- One sub-module, cond_check: combinational cond + flags -> cpass, reused later by pipelined variants.

Test Plan:
- REG ADD, cond=00, imem_ready on first cycle: FETCH, DECODE, EXEC (flag_write), WB (reg_write=1) → 4 cycles, instr_count=1.
- Load (tipo=10, mem_write_d=0), dmem_ready delayed 3 cycles: dmem_req high 4 cycles, then reg_write one cycle; store variant: mem_write high 4 cycles, no reg_write.
- Branch with cond=01: with flags Z=1, pc_write=1 and pc_src=1 in EXEC; with Z=0, no pc_write, and instr_count still increments.
- imem_ready held low, MEM_TIMEOUT=16: ERROR entered after 16 FETCH cycles, error=1, and state stays ERROR until rst.
- HALT (tipo=11, opcode=111): halted=1 and no further imem_req; asserting rst returns to FETCH with instr_count=0.
- rst asserted in MEM mid-wait: the next cycle is FETCH, with dmem_req=0 and mem_write=0.
